// File: rtl/frame_scheduler_pkg.sv
// frame_scheduler_pkg: shared state encoding and default timing constants
package frame_scheduler_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_DATA, START, ACTIVE, LATCH, HOLDOFF} state_e;
   localparam int DEF_FIFO_ADDR_WIDTH   = 13;
   localparam int DEF_FRAME_WORDS       = 4096;
   localparam int DEF_LATCH_CYCLES      = 6000;
   localparam int DEF_MIN_PERIOD_CYCLES = 400000;
   localparam int DEF_TIMEOUT_CYCLES    = 2000000;
endpackage

// File: rtl/frame_scheduler_counter.sv
// sched_counter: loadable down-counter that parks at zero and flags done
module sched_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic         count_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);
   logic [W-1:0] cnt_q;
   // load wins over counting; counting stops at zero so the value saturates
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else if (load_i) cnt_q <= load_val_i;
      else if (count_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   assign done_o = cnt_q == '0;
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: LED frame launch/latch/rate-limit FSM; optional WAIT_DATA timeout via FRAME_SCHEDULER_TIMEOUT_EN
module frame_scheduler
   import frame_scheduler_pkg::*;
#(
   parameter int FIFO_ADDR_WIDTH   = DEF_FIFO_ADDR_WIDTH,
   parameter int FRAME_WORDS       = DEF_FRAME_WORDS,
   parameter int LATCH_CYCLES      = DEF_LATCH_CYCLES,
   parameter int MIN_PERIOD_CYCLES = DEF_MIN_PERIOD_CYCLES,
   parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
   input  logic                     strings_active,
   input  logic                     fifo_underflow,
   input  logic                     clear_flags,
   output logic                     h_blank,
   output logic                     frame_start,
   output logic                     busy,
   output logic [15:0]              frame_count,
   output logic                     underrun_flag,
   output logic                     timeout_flag
);
   localparam logic [FIFO_ADDR_WIDTH:0] FW_THR = (FIFO_ADDR_WIDTH+1)'(FRAME_WORDS);
   localparam int LW = $clog2(LATCH_CYCLES + 1);
   localparam int PW = $clog2(MIN_PERIOD_CYCLES + 1);
   if (FRAME_WORDS < 1 || LATCH_CYCLES < 1 || MIN_PERIOD_CYCLES < LATCH_CYCLES + 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("frame_scheduler: invalid timing parameters");
   end
   state_e      state_q, state_d;
   logic        seen_q, seen_d;
   logic        h_blank_q, h_blank_d, frame_start_q, frame_start_d, busy_q, busy_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        underrun_q, underrun_d;
   logic        latch_done, period_done, wait_done;
   wire         data_ready = fifo_full_count >= FW_THR;
   // LATCH length: loaded on entry with LATCH_CYCLES-1 so the state lasts exactly LATCH_CYCLES cycles
   sched_counter #(.W(LW)) u_latch (
      .clk, .reset_n,
      .load_i     (state_q != LATCH && state_d == LATCH),
      .count_i    (state_q == LATCH),
      .load_val_i (LW'(LATCH_CYCLES - 1)),
      .done_o     (latch_done)
   );
   // frame period: reloaded at the end of START; the offset of 3 covers the START,
   // HOLDOFF->WAIT_DATA and WAIT_DATA->START cycles so launches are at least MIN_PERIOD_CYCLES apart
   sched_counter #(.W(PW)) u_period (
      .clk, .reset_n,
      .load_i     (state_q == START),
      .count_i    (1'b1),
      .load_val_i (PW'(MIN_PERIOD_CYCLES - 3)),
      .done_o     (period_done)
   );
   // next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      seen_d  = seen_q;
      case (state_q)
         IDLE:      if (enable) state_d = WAIT_DATA;
         WAIT_DATA: if (!enable) state_d = IDLE;
                    else if (data_ready) state_d = START;
                    else if (wait_done) state_d = IDLE;
         START:     begin
                       state_d = ACTIVE;
                       seen_d  = 1'b0;
                    end
         ACTIVE:    if (seen_q && !strings_active) state_d = LATCH;
                    else if (strings_active) seen_d = 1'b1;
         LATCH:     if (latch_done) state_d = HOLDOFF;
         HOLDOFF:   if (period_done) state_d = enable ? WAIT_DATA : IDLE;
         default:   state_d = IDLE;
      endcase
      h_blank_d     = !(state_d == START || state_d == ACTIVE);
      busy_d        = state_d == START || state_d == ACTIVE;
      frame_start_d = state_d == START;
      frame_count_d = frame_count_q + ((state_q == LATCH && latch_done) ? 16'd1 : 16'd0);
      underrun_d    = (state_q == ACTIVE && fifo_underflow) || (underrun_q && !clear_flags);
   end
   // state and output registers
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q       <= IDLE;
         seen_q        <= 1'b0;
         h_blank_q     <= 1'b1;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
         frame_count_q <= '0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         seen_q        <= seen_d;
         h_blank_q     <= h_blank_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
         frame_count_q <= frame_count_d;
         underrun_q    <= underrun_d;
      end
`ifdef FRAME_SCHEDULER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic timeout_q;
   // WAIT_DATA dwell limit, restarted on every entry into WAIT_DATA
   sched_counter #(.W(TW)) u_timeout (
      .clk, .reset_n,
      .load_i     (state_q != WAIT_DATA && state_d == WAIT_DATA),
      .count_i    (state_q == WAIT_DATA),
      .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
      .done_o     (wait_done)
   );
   // sticky timeout flag; a timeout in the same cycle as a clear keeps it set
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) timeout_q <= 1'b0;
      else timeout_q <= (state_q == WAIT_DATA && state_d == IDLE && enable) || (timeout_q && !clear_flags);
   assign timeout_flag = timeout_q;
`else
   assign wait_done    = 1'b0;
   assign timeout_flag = 1'b0;
`endif
   assign h_blank       = h_blank_q;
   assign frame_start   = frame_start_q;
   assign busy          = busy_q;
   assign frame_count   = frame_count_q;
   assign underrun_flag = underrun_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: timestamp-based reference model plus directed and random stimulus
module tb_frame_scheduler;
   localparam int FAW = 4, FW = 8, LC = 10, MP = 40, TO = 100;
`ifdef FRAME_SCHEDULER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int P_IDLE = 0, P_WAIT = 1, P_START = 2, P_ACTIVE = 3, P_LATCH = 4, P_HOLD = 5;
   logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, strings_active = 1'b0, fifo_underflow = 1'b0, clear_flags = 1'b0;
   logic [FAW:0] fifo_full_count = '0;
   logic h_blank, frame_start, busy, underrun_flag, timeout_flag;
   logic [15:0] frame_count;
   int total = 0, passed = 0;
   frame_scheduler #(.FIFO_ADDR_WIDTH(FAW), .FRAME_WORDS(FW), .LATCH_CYCLES(LC),
                     .MIN_PERIOD_CYCLES(MP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_full_count(fifo_full_count),
      .strings_active(strings_active), .fifo_underflow(fifo_underflow), .clear_flags(clear_flags),
      .h_blank(h_blank), .frame_start(frame_start), .busy(busy), .frame_count(frame_count),
      .underrun_flag(underrun_flag), .timeout_flag(timeout_flag));
   always #25 clk = ~clk;
   // model: phase plus the edge numbers at which waiting, launch and latch began
   int ph = P_IDLE, n = 0, t_wait = 0, t_start = 0, t_latch = 0;
   bit seen = 0, m_uf = 0, m_tf = 0;
   logic [15:0] m_fc = '0;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask
   task automatic mreset();
      ph = P_IDLE; n = 0; seen = 0; m_uf = 0; m_tf = 0; m_fc = '0;
   endtask
   task automatic step();
      bit was_active, to_ev;
      was_active = ph == P_ACTIVE;
      to_ev = 0;
      n++;
      case (ph)
         P_IDLE:   if (enable) begin ph = P_WAIT; t_wait = n; end
         P_WAIT:   if (!enable) ph = P_IDLE;
                   else if (int'(fifo_full_count) >= FW) begin ph = P_START; t_start = n; end
                   else if (TO_EN && n - t_wait >= TO) begin ph = P_IDLE; to_ev = 1; end
         P_START:  begin ph = P_ACTIVE; seen = 0; end
         P_ACTIVE: if (!strings_active && seen) begin ph = P_LATCH; t_latch = n; end
                   else if (strings_active) seen = 1;
         P_LATCH:  if (n - t_latch >= LC) begin ph = P_HOLD; m_fc++; end
         P_HOLD:   if (n - t_start >= MP - 1) begin
                      ph = enable ? P_WAIT : P_IDLE;
                      t_wait = n;
                   end
         default:  ph = P_IDLE;
      endcase
      m_uf = (was_active && fifo_underflow) || (m_uf && !clear_flags);
      m_tf = to_ev || (m_tf && !clear_flags);
   endtask
   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) mreset();
      else step();
   end
   // compare DUT against model on every falling edge out of reset, plus launch spacing
   int ncyc = 0, last_fs = -1;
   initial forever begin
      @(negedge clk);
      ncyc++;
      if (!reset_n) last_fs = -1;
      else begin
         check("h_blank", h_blank, !(ph == P_START || ph == P_ACTIVE));
         check("busy", busy, ph == P_START || ph == P_ACTIVE);
         check("frame_start", frame_start, ph == P_START);
         check("frame_count", frame_count, m_fc);
         check("underrun_flag", underrun_flag, m_uf);
         check("timeout_flag", timeout_flag, m_tf);
         if (frame_start) begin
            if (last_fs >= 0) begin
               total++;
               if (ncyc - last_fs >= MP) passed++;
               else $display("FAIL fs_spacing: got %0d cycles required >= %0d", ncyc - last_fs, MP);
            end
            last_fs = ncyc;
         end
      end
   end
   initial begin
      repeat (3) @(negedge clk);
      check("rst_h_blank", h_blank, 1);
      check("rst_frame_start", frame_start, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_underrun", underrun_flag, 0);
      check("rst_timeout", timeout_flag, 0);
      reset_n = 1; enable = 1; fifo_full_count = 7;
      repeat (4) @(negedge clk);
      check("short_fifo_h_blank", h_blank, 1);
      check("short_fifo_no_start", frame_start, 0);
      fifo_full_count = 8;
      @(negedge clk);
      check("start_pulse", frame_start, 1);
      check("start_h_blank", h_blank, 0);
      check("start_busy", busy, 1);
      fifo_full_count = 0;
      @(negedge clk);
      check("active_no_pulse", frame_start, 0);
      check("active_busy", busy, 1);
      strings_active = 1;
      repeat (3) @(negedge clk);
      fifo_underflow = 1;
      @(negedge clk);
      fifo_underflow = 0;
      check("underrun_set", underrun_flag, 1);
      fifo_underflow = 1; clear_flags = 1;
      @(negedge clk);
      fifo_underflow = 0; clear_flags = 0;
      check("underrun_set_beats_clear", underrun_flag, 1);
      clear_flags = 1;
      @(negedge clk);
      clear_flags = 0;
      check("underrun_cleared", underrun_flag, 0);
      repeat (9) @(negedge clk);
      strings_active = 0;
      @(negedge clk);
      check("latch_h_blank", h_blank, 1);
      check("latch_not_busy", busy, 0);
      repeat (9) @(negedge clk);
      check("latch_count_pending", frame_count, 0);
      @(negedge clk);
      check("latch_count_done", frame_count, 1);
      enable = 0;
      repeat (60) @(negedge clk);
      enable = 1; fifo_full_count = 3;
      repeat (100) @(negedge clk);
      check("timeout_not_yet", timeout_flag, 0);
      @(negedge clk);
      check("timeout_flag", timeout_flag, TO_EN);
      check("timeout_h_blank", h_blank, 1);
      fifo_full_count = 8;
      @(negedge clk);
      check("wait_start_direct", frame_start, !TO_EN);
      @(negedge clk);
      check("wait_start_via_idle", frame_start, TO_EN);
      fifo_full_count = 0; clear_flags = 1;
      @(negedge clk);
      clear_flags = 0;
      check("timeout_cleared", timeout_flag, 0);
      check("pre_reset_count", frame_count, 1);
      check("pre_reset_busy", busy, 1);
      #5 reset_n = 0;
      #1;
      check("async_rst_h_blank", h_blank, 1);
      check("async_rst_count", frame_count, 0);
      check("async_rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         enable = $urandom_range(0, 99) < 95;
         fifo_full_count = (i % 300 < 120) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) strings_active = ~strings_active;
         fifo_underflow = $urandom_range(0, 9) == 0;
         clear_flags = $urandom_range(0, 14) == 0;
      end
      enable = 0; fifo_underflow = 0; clear_flags = 0; strings_active = 0;
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
